// File: rtl/uart_resp_pkg.sv
// Shared types and sizing for the UART response transmitter.
// UART_RESP_TX_PARITY_EN selects 8E1 framing (11 bits) instead of 8N1 (10 bits).
package uart_resp_pkg;

    typedef enum logic [1:0] {IDLE, HIGH_BYTE, LOW_BYTE} resp_tx_state_t;

    localparam int BAUD_DIV_DEFAULT = 2604;
`ifdef UART_RESP_TX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif
    localparam int BAUD_CNT_W = 12;
    // Bits that follow the start bit: data LSB first, optional parity, stop.
    localparam int PAYLOAD_W  = FRAME_BITS - 1;

    function automatic logic [PAYLOAD_W-1:0] frame_payload(input logic [7:0] data);
`ifdef UART_RESP_TX_PARITY_EN
        return {1'b1, ^data, data};
`else
        return {1'b1, data};
`endif
    endfunction

endpackage

// File: rtl/uart_resp_tx_if.sv
// Handshake and line signals between the command processor and the response transmitter.
// master = command processor side, slave = transmitter side.
interface uart_resp_tx_if;
    logic        send;
    logic [15:0] resp;
    logic        TX;
    logic        busy;
    logic        resp_sent;

    modport master (output send, resp, input TX, busy, resp_sent);
    modport slave  (input send, resp, output TX, busy, resp_sent);
endinterface

// File: rtl/uart_tx_byte.sv
// Byte serializer: start bit, data LSB first, [even parity if UART_RESP_TX_PARITY_EN], stop bit.
// Latency: TX drives the start bit from the trmt edge; tx_done is high in the last clk of the stop bit.
// Backpressure: trmt is taken only when idle or in the tx_done cycle, so reloads are gap-free.
module uart_tx_byte
    import uart_resp_pkg::*;
#(
    parameter int BAUD_DIV = BAUD_DIV_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       trmt,
    input  logic [7:0] tx_data,
    output logic       TX,
    output logic       tx_done
);

    localparam logic [BAUD_CNT_W-1:0] BAUD_LAST = BAUD_CNT_W'(BAUD_DIV - 1);
    localparam logic [3:0]            BIT_LAST  = 4'(FRAME_BITS - 1);

    logic                  active_q, active_d;
    logic [BAUD_CNT_W-1:0] baud_cnt_q, baud_cnt_d;
    logic [3:0]            bit_cnt_q, bit_cnt_d;
    logic [PAYLOAD_W-1:0]  shift_q, shift_d;
    logic                  tx_q, tx_d;
    logic                  bit_end;

    always_comb begin
        bit_end    = active_q && (baud_cnt_q == BAUD_LAST);
        tx_done    = bit_end && (bit_cnt_q == BIT_LAST);
        active_d   = active_q;
        baud_cnt_d = baud_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        tx_d       = tx_q;

        if (active_q) begin
            baud_cnt_d = bit_end ? '0 : baud_cnt_q + BAUD_CNT_W'(1);
            if (tx_done) begin
                active_d  = 1'b0;
                bit_cnt_d = '0;
                tx_d      = 1'b1;
            end else if (bit_end) begin
                bit_cnt_d = bit_cnt_q + 4'd1;
                tx_d      = shift_q[0];
                shift_d   = {1'b1, shift_q[PAYLOAD_W-1:1]};
            end
        end

        // A load in the tx_done cycle overrides the return to idle.
        if (trmt && (!active_q || tx_done)) begin
            active_d   = 1'b1;
            baud_cnt_d = '0;
            bit_cnt_d  = '0;
            shift_d    = frame_payload(tx_data);
            tx_d       = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active_q   <= 1'b0;
            baud_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '1;
            tx_q       <= 1'b1;
        end else begin
            active_q   <= active_d;
            baud_cnt_q <= baud_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
        end
    end

    assign TX = tx_q;

endmodule

// File: rtl/uart_resp_tx.sv
// Sends a 16-bit response as two UART frames, high byte first (8E1 if UART_RESP_TX_PARITY_EN, else 8N1).
// Latency: start bit from the accepting edge; busy falls 2*FRAME_BITS*BAUD_DIV clks later.
// Backpressure: send is ignored while busy; resp_sent holds until the next accepted send.
module uart_resp_tx
    import uart_resp_pkg::*;
#(
    parameter int BAUD_DIV = BAUD_DIV_DEFAULT
) (
    input  logic           clk,
    input  logic           rst,
    uart_resp_tx_if.slave  bus
);

    resp_tx_state_t state_q, state_d;
    logic [7:0]     resp_lo_q, resp_lo_d;
    logic           busy_q, busy_d;
    logic           resp_sent_q, resp_sent_d;
    logic           trmt;
    logic [7:0]     tx_byte;
    logic           tx_done;
    logic           tx_line;

    always_comb begin
        state_d     = state_q;
        resp_lo_d   = resp_lo_q;
        busy_d      = busy_q;
        resp_sent_d = resp_sent_q;
        trmt        = 1'b0;
        tx_byte     = resp_lo_q;

        unique case (state_q)
            IDLE: begin
                // The high byte goes straight from the input so its start bit begins on the accept edge.
                if (bus.send && !busy_q) begin
                    state_d     = HIGH_BYTE;
                    resp_lo_d   = bus.resp[7:0];
                    busy_d      = 1'b1;
                    resp_sent_d = 1'b0;
                    trmt        = 1'b1;
                    tx_byte     = bus.resp[15:8];
                end
            end
            HIGH_BYTE: begin
                if (tx_done) begin
                    state_d = LOW_BYTE;
                    trmt    = 1'b1;
                end
            end
            LOW_BYTE: begin
                if (tx_done) begin
                    state_d     = IDLE;
                    busy_d      = 1'b0;
                    resp_sent_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            resp_lo_q   <= '0;
            busy_q      <= 1'b0;
            resp_sent_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            resp_lo_q   <= resp_lo_d;
            busy_q      <= busy_d;
            resp_sent_q <= resp_sent_d;
        end
    end

    uart_tx_byte #(
        .BAUD_DIV (BAUD_DIV)
    ) u_tx_byte (
        .clk     (clk),
        .rst     (rst),
        .trmt    (trmt),
        .tx_data (tx_byte),
        .TX      (tx_line),
        .tx_done (tx_done)
    );

    assign bus.TX        = tx_line;
    assign bus.busy      = busy_q;
    assign bus.resp_sent = resp_sent_q;

endmodule

// File: tb/tb_uart_resp_tx.sv
// Randomized bench for uart_resp_tx against a word-level line model; BAUD_DIV=4.
// Directed cases pin the model with hand-written bit sequences and busy length.
module tb_uart_resp_tx;
    import uart_resp_pkg::*;

    localparam int B         = 4;
    localparam int WORD_BITS = 2 * FRAME_BITS;
    localparam int WORD_CLKS = WORD_BITS * B;

`ifdef UART_RESP_TX_PARITY_EN
    localparam logic [15:0]          LIT_WORD = 16'h0701;
    localparam logic [WORD_BITS-1:0] LIT_SEQ  = 22'b11000000010_11000001110;
    localparam int                   LIT_BUSY = 88;
`else
    localparam logic [15:0]          LIT_WORD = 16'hA55A;
    localparam logic [WORD_BITS-1:0] LIT_SEQ  = 20'b1010110100_1101001010;
    localparam int                   LIT_BUSY = 80;
`endif

    logic clk;
    logic rst;
    bit   chk_en;
    int   vectors;
    int   miscompares;

    uart_resp_tx_if bus ();

    uart_resp_tx #(.BAUD_DIV(B)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Line image of one word: index k is the k-th bit on the wire.
    function automatic logic [WORD_BITS-1:0] build(input logic [15:0] w);
        logic [WORD_BITS-1:0] v;
        logic [7:0]           b;
        int                   base;
        v = '1;
        for (int j = 0; j < 2; j++) begin
            b    = (j == 0) ? w[15:8] : w[7:0];
            base = j * FRAME_BITS;
            v[base] = 1'b0;
            for (int i = 0; i < 8; i++) v[base + 1 + i] = b[i];
`ifdef UART_RESP_TX_PARITY_EN
            v[base + 9] = 1'($countones(b) % 2);
`endif
            v[base + FRAME_BITS - 1] = 1'b1;
        end
        return v;
    endfunction

    // Model: a word occupies the line for WORD_CLKS clks after the accepting edge.
    bit                   m_active;
    bit                   m_sent;
    bit                   m_was_busy;
    int                   m_t;
    logic [WORD_BITS-1:0] m_bits;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_active = 1'b0;
            m_sent   = 1'b0;
            m_t      = 0;
        end else begin
            m_was_busy = m_active;
            if (m_active) begin
                m_t++;
                if (m_t == WORD_CLKS) begin
                    m_active = 1'b0;
                    m_sent   = 1'b1;
                end
            end
            if (!m_was_busy && bus.send) begin
                m_active = 1'b1;
                m_t      = 0;
                m_sent   = 1'b0;
                m_bits   = build(bus.resp);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at time %0t", name, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("tx_line", 32'(bus.TX), 32'(m_active ? m_bits[m_t / B] : 1'b1));
            chk("busy", 32'(bus.busy), 32'(m_active));
            chk("resp_sent", 32'(bus.resp_sent), 32'(m_sent));
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic accept_word(input logic [15:0] w);
        tick();
        bus.send = 1'b1;
        bus.resp = w;
        tick();
        bus.send = 1'b0;
        bus.resp = 16'($urandom);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (bus.busy && n < 2000) begin
            tick();
            n++;
        end
        if (bus.busy) begin
            vectors++;
            miscompares++;
            $display("FAIL wait_idle: busy still 1 after %0d clks, required 0", n);
        end
    endtask

    int                   pos;
    int                   busy_len;
    logic [WORD_BITS-1:0] got;
    logic [WORD_BITS-1:0] lit_seq;

    initial begin
        clk      = 1'b0;
        rst      = 1'b0;
        bus.send = 1'b0;
        bus.resp = '0;
        #1;
        rst    = 1'b1;
        chk_en = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b0;

        // Idle after reset.
        repeat (100) tick();
        chk("reset_tx", 32'(bus.TX), 1);
        chk("reset_busy", 32'(bus.busy), 0);
        chk("reset_resp_sent", 32'(bus.resp_sent), 0);

        // Model and DUT against a hand-written line image.
        lit_seq = LIT_SEQ;
        chk("model_seq", 32'(build(LIT_WORD)), 32'(lit_seq));
        accept_word(LIT_WORD);
        pos = 0;
        for (int k = 0; k < WORD_BITS; k++) begin
            while (pos < k * B + B / 2) begin
                tick();
                pos++;
            end
            got[k] = bus.TX;
        end
        chk("line_seq", 32'(got), 32'(lit_seq));
        busy_len = pos;
        while (bus.busy && busy_len < 1000) begin
            tick();
            busy_len++;
        end
        chk("busy_len", 32'(busy_len), 32'(LIT_BUSY));
        chk("sent_at_end", 32'(bus.resp_sent), 1);
        repeat (10) tick();
        chk("sent_holds", 32'(bus.resp_sent), 1);

        // Send while busy is ignored.
        accept_word(16'h1234);
        repeat (9) tick();
        bus.send = 1'b1;
        bus.resp = 16'hFFFF;
        tick();
        bus.send = 1'b0;
        chk("ignored_send_busy", 32'(bus.busy), 1);
        wait_idle();
        chk("ignored_send_done", 32'(bus.resp_sent), 1);

        // Back-to-back: second send in the first idle cycle.
        repeat (3) tick();
        accept_word(16'h00FF);
        wait_idle();
        chk("b2b_sent_pulse", 32'(bus.resp_sent), 1);
        bus.send = 1'b1;
        bus.resp = 16'h8001;
        tick();
        bus.send = 1'b0;
        chk("b2b_sent_cleared", 32'(bus.resp_sent), 0);
        chk("b2b_busy", 32'(bus.busy), 1);
        wait_idle();

        // Mid-frame reset while the line is low.
        accept_word(16'hC3C3);
        repeat (22) tick();
        rst = 1'b1;
        #1;
        chk("mid_rst_tx", 32'(bus.TX), 1);
        chk("mid_rst_busy", 32'(bus.busy), 0);
        repeat (2) tick();
        rst = 1'b0;
        accept_word(16'h0001);
        wait_idle();
        chk("post_rst_sent", 32'(bus.resp_sent), 1);

        // Random traffic, including sends while busy.
        for (int i = 0; i < 3000; i++) begin
            tick();
            bus.send = ($urandom_range(0, 5) == 0);
            bus.resp = 16'($urandom);
        end
        bus.send = 1'b0;
        wait_idle();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
